// File: rtl/alarm_pkg.sv
// Shared types, limits and helpers for the alarm stage.
package alarm_pkg;

    localparam int unsigned TW             = 8;
    localparam int unsigned MAX_HOUR       = 23;
    localparam int unsigned MAX_MIN        = 59;
    localparam int unsigned RST_ALARM_HOUR = 7;
    localparam int unsigned RST_ALARM_MIN  = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } alarm_state_t;

    typedef struct packed {
        logic [TW-1:0] hour;
        logic [TW-1:0] minute;
    } hm_t;

    // Adds inc minutes with carry into the hour and wrap at midnight; inc must be <= MAX_MIN.
    function automatic hm_t add_minutes(input hm_t t, input int unsigned inc);
        hm_t r;
        r.hour   = t.hour;
        r.minute = t.minute + TW'(inc);
        if (r.minute > TW'(MAX_MIN)) begin
            r.minute = r.minute - TW'(MAX_MIN + 1);
            r.hour   = (t.hour >= TW'(MAX_HOUR)) ? '0 : t.hour + TW'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_blinker.sv
// Ring LED blinker: starts high on start, then toggles every BLINK_DIV cycles while enabled.
module alarm_blinker #(
    parameter int unsigned BLINK_DIV = 50_000_000
) (
    input  logic CLK100MHZ,
    input  logic CPU_RESETN,
    input  logic start,
    input  logic enable,
    output logic ring_led
);

    localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN || !enable) begin
            cnt      <= '0;
            ring_led <= 1'b0;
        end else if (start) begin
            cnt      <= '0;
            ring_led <= 1'b1;
        end else if (cnt == CW'(BLINK_DIV - 1)) begin
            cnt      <= '0;
            ring_led <= ~ring_led;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alarm_unit.sv
// Alarm stage: settable alarm time, ring/timeout FSM, blinking LED.
// Optional snooze support is built when ALARM_SNOOZE_EN is defined.
module alarm_unit
    import alarm_pkg::*;
#(
    parameter int unsigned SNOOZE_MIN     = 5,
    parameter int unsigned RING_TIMEOUT_S = 60,
    parameter int unsigned BLINK_DIV      = 50_000_000
) (
    input  logic          CLK100MHZ,
    input  logic          CPU_RESETN,
    input  logic [TW-1:0] hours,
    input  logic [TW-1:0] minutes,
    input  logic [TW-1:0] seconds,
    input  logic          arm_sw,
    input  logic          set_hour_pos,
    input  logic          set_min_pos,
    input  logic          snooze_pos,
    input  logic          stop_pos,
    output logic [TW-1:0] alarm_hours,
    output logic [TW-1:0] alarm_minutes,
    output logic          armed,
    output logic          ringing,
    output logic          ring_led
);

    alarm_state_t  state, state_n;
    logic [TW-1:0] sec_prev;
    logic [7:0]    tcnt, tcnt_n;
    logic          sec_evt_c;
    logic          match_alarm_c;
    logic          enter_ring_c;

    assign sec_evt_c     = (seconds != sec_prev);
    assign match_alarm_c = sec_evt_c && (seconds == '0) &&
                           (hours == alarm_hours) && (minutes == alarm_minutes);
    assign enter_ring_c  = (state_n == RINGING) && (state != RINGING);

`ifdef ALARM_SNOOZE_EN
    hm_t  snz, snz_n, live_c;
    logic match_snz_c;

    assign live_c.hour   = hours;
    assign live_c.minute = minutes;
    assign match_snz_c   = sec_evt_c && (seconds == '0) &&
                           (hours == snz.hour) && (minutes == snz.minute);

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) snz <= '0;
        else             snz <= snz_n;
    end
`else
    logic unused_snooze_c;
    assign unused_snooze_c = snooze_pos & (SNOOZE_MIN > 0);
`endif

    // State, counters and registered status outputs
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            state    <= IDLE;
            tcnt     <= '0;
            sec_prev <= '0;
            armed    <= 1'b0;
            ringing  <= 1'b0;
        end else begin
            state    <= state_n;
            tcnt     <= tcnt_n;
            sec_prev <= seconds;
            armed    <= (state_n != IDLE);
            ringing  <= (state_n == RINGING);
        end
    end

    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
`ifdef ALARM_SNOOZE_EN
        snz_n   = snz;
`endif
        if (!arm_sw) begin
            state_n = IDLE;
            tcnt_n  = '0;
        end else begin
            case (state)
                IDLE: state_n = ARMED;
                ARMED: begin
                    if (match_alarm_c) begin
                        state_n = RINGING;
                        tcnt_n  = '0;
                    end
                end
                RINGING: begin
                    if (stop_pos) begin
                        state_n = ARMED;
                    end
`ifdef ALARM_SNOOZE_EN
                    else if (snooze_pos) begin
                        state_n = SNOOZE;
                        snz_n   = add_minutes(live_c, SNOOZE_MIN);
                    end
`endif
                    else if (sec_evt_c) begin
                        // The event that triggered the ring was seen in ARMED, so it is not counted here
                        if (tcnt == 8'(RING_TIMEOUT_S - 1)) state_n = ARMED;
                        else                                tcnt_n  = tcnt + 8'd1;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (match_snz_c) begin
                        state_n = RINGING;
                        tcnt_n  = '0;
                    end else if (stop_pos) begin
                        state_n = ARMED;
                    end
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    // Alarm time is editable only while not ringing or snoozing
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            alarm_hours   <= TW'(RST_ALARM_HOUR);
            alarm_minutes <= TW'(RST_ALARM_MIN);
        end else if (state == IDLE || state == ARMED) begin
            if (set_hour_pos)
                alarm_hours <= (alarm_hours >= TW'(MAX_HOUR)) ? '0 : alarm_hours + TW'(1);
            if (set_min_pos)
                alarm_minutes <= (alarm_minutes >= TW'(MAX_MIN)) ? '0 : alarm_minutes + TW'(1);
        end
    end

    alarm_blinker #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blinker (
        .CLK100MHZ  (CLK100MHZ),
        .CPU_RESETN (CPU_RESETN),
        .start      (enter_ring_c),
        .enable     (state_n == RINGING),
        .ring_led   (ring_led)
    );

endmodule

// File: tb/tb_alarm_unit.sv
// Scoreboard bench for alarm_unit (BLINK_DIV=4, RING_TIMEOUT_S=3, SNOOZE_MIN=5).
module tb_alarm_unit;

    logic       CLK100MHZ = 1'b0;
    logic       CPU_RESETN = 1'b0;
    logic [7:0] hours = '0, minutes = '0, seconds = '0;
    logic       arm_sw = 1'b0, set_hour_pos = 1'b0, set_min_pos = 1'b0;
    logic       snooze_pos = 1'b0, stop_pos = 1'b0;
    logic [7:0] alarm_hours, alarm_minutes;
    logic       armed, ringing, ring_led;

`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [18:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;

    alarm_unit #(
        .SNOOZE_MIN     (5),
        .RING_TIMEOUT_S (3),
        .BLINK_DIV      (4)
    ) dut (
        .CLK100MHZ     (CLK100MHZ),
        .CPU_RESETN    (CPU_RESETN),
        .hours         (hours),
        .minutes       (minutes),
        .seconds       (seconds),
        .arm_sw        (arm_sw),
        .set_hour_pos  (set_hour_pos),
        .set_min_pos   (set_min_pos),
        .snooze_pos    (snooze_pos),
        .stop_pos      (stop_pos),
        .alarm_hours   (alarm_hours),
        .alarm_minutes (alarm_minutes),
        .armed         (armed),
        .ringing       (ringing),
        .ring_led      (ring_led)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    function automatic logic [18:0] pk(input logic [7:0] h, input logic [7:0] m,
                                       input logic a, input logic r, input logic l);
        return {h, m, a, r, l};
    endfunction

    function automatic logic [18:0] obs();
        return {alarm_hours, alarm_minutes, armed, ringing, ring_led};
    endfunction

    task automatic tick();
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hours   = 8'(h);
        minutes = 8'(m);
        seconds = 8'(s);
    endtask

    task automatic test_reset();
        CPU_RESETN = 1'b0;
        tick();
        tick();
        CPU_RESETN = 1'b1;
        sb.push_back('{"reset", pk(8'd7, 8'd0, 1'b0, 1'b0, 1'b0)});
        tick();
        e = sb.pop_front(); n_vec++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
    endtask

    task automatic test_set_minute();
        for (int i = 1; i <= 3; i++) begin
            set_min_pos = 1'b1;
            sb.push_back('{"set_min", pk(8'd7, 8'(i), 1'b0, 1'b0, 1'b0)});
            tick();
            set_min_pos = 1'b0;
            e = sb.pop_front(); n_vec++;
            if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
        end
    endtask

    task automatic test_ring_blink();
        arm_sw = 1'b1;
        sb.push_back('{"arm", pk(8'd7, 8'd3, 1'b1, 1'b0, 1'b0)});
        tick();
        e = sb.pop_front(); n_vec++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
        set_time(7, 2, 59);
        sb.push_back('{"pre_match", pk(8'd7, 8'd3, 1'b1, 1'b0, 1'b0)});
        tick();
        e = sb.pop_front(); n_vec++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
        set_time(7, 3, 0);
        for (int k = 0; k <= 8; k++) begin
            sb.push_back('{$sformatf("blink_k%0d", k), pk(8'd7, 8'd3, 1'b1, 1'b1, ((k / 4) % 2) == 0)});
            tick();
            e = sb.pop_front(); n_vec++;
            if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
        end
    endtask

    task automatic test_timeout();
        for (int s = 1; s <= 3; s++) begin
            seconds = 8'(s);
            sb.push_back('{$sformatf("timeout_s%0d", s),
                           pk(8'd7, 8'd3, 1'b1, s < 3, (s < 3) && (((8 + s) / 4) % 2 == 0))});
            tick();
            e = sb.pop_front(); n_vec++;
            if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
        end
        set_time(7, 2, 59);
        sb.push_back('{"next_day_pre", pk(8'd7, 8'd3, 1'b1, 1'b0, 1'b0)});
        tick();
        e = sb.pop_front(); n_vec++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
        set_time(7, 3, 0);
        sb.push_back('{"next_day_ring", pk(8'd7, 8'd3, 1'b1, 1'b1, 1'b1)});
        tick();
        e = sb.pop_front(); n_vec++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
    endtask

    task automatic test_stop_priority();
        set_min_pos = 1'b1;
        sb.push_back('{"set_in_ring", pk(8'd7, 8'd3, 1'b1, 1'b1, 1'b1)});
        tick();
        set_min_pos = 1'b0;
        e = sb.pop_front(); n_vec++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
        stop_pos   = 1'b1;
        snooze_pos = 1'b1;
        sb.push_back('{"stop_beats_snooze", pk(8'd7, 8'd3, 1'b1, 1'b0, 1'b0)});
        tick();
        stop_pos   = 1'b0;
        snooze_pos = 1'b0;
        e = sb.pop_front(); n_vec++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
    endtask

    task automatic test_snooze();
        set_hour_pos = 1'b1;
        repeat (16) tick();
        set_hour_pos = 1'b0;
        set_min_pos  = 1'b1;
        repeat (55) tick();
        set_min_pos  = 1'b0;
        set_time(23, 57, 59);
        sb.push_back('{"set_2358", pk(8'd23, 8'd58, 1'b1, 1'b0, 1'b0)});
        tick();
        e = sb.pop_front(); n_vec++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
        set_time(23, 58, 0);
        sb.push_back('{"ring_2358", pk(8'd23, 8'd58, 1'b1, 1'b1, 1'b1)});
        tick();
        e = sb.pop_front(); n_vec++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
        snooze_pos = 1'b1;
        sb.push_back('{"snooze", pk(8'd23, 8'd58, 1'b1, !SNZ, !SNZ)});
        tick();
        snooze_pos = 1'b0;
        e = sb.pop_front(); n_vec++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
        set_time(0, 2, 59);
        sb.push_back('{"snooze_wait", pk(8'd23, 8'd58, 1'b1, !SNZ, !SNZ)});
        tick();
        e = sb.pop_front(); n_vec++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
        set_time(0, 3, 0);
        sb.push_back('{"snooze_ring", pk(8'd23, 8'd58, 1'b1, 1'b1, 1'b1)});
        tick();
        e = sb.pop_front(); n_vec++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
        stop_pos = 1'b1;
        sb.push_back('{"snooze_stop", pk(8'd23, 8'd58, 1'b1, 1'b0, 1'b0)});
        tick();
        stop_pos = 1'b0;
        e = sb.pop_front(); n_vec++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
    endtask

    task automatic test_reset_mid_ring();
        set_time(23, 57, 59);
        sb.push_back('{"rst_pre", pk(8'd23, 8'd58, 1'b1, 1'b0, 1'b0)});
        tick();
        e = sb.pop_front(); n_vec++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
        set_time(23, 58, 0);
        sb.push_back('{"rst_ring", pk(8'd23, 8'd58, 1'b1, 1'b1, 1'b1)});
        tick();
        e = sb.pop_front(); n_vec++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
        CPU_RESETN = 1'b0;
        sb.push_back('{"rst_mid_ring", pk(8'd7, 8'd0, 1'b0, 1'b0, 1'b0)});
        tick();
        CPU_RESETN = 1'b1;
        e = sb.pop_front(); n_vec++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
        sb.push_back('{"rearm", pk(8'd7, 8'd0, 1'b1, 1'b0, 1'b0)});
        tick();
        e = sb.pop_front(); n_vec++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
    endtask

    task automatic test_min_wrap();
        set_min_pos = 1'b1;
        repeat (58) tick();
        sb.push_back('{"min_59", pk(8'd7, 8'd59, 1'b1, 1'b0, 1'b0)});
        tick();
        e = sb.pop_front(); n_vec++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
        sb.push_back('{"min_wrap", pk(8'd7, 8'd0, 1'b1, 1'b0, 1'b0)});
        tick();
        set_min_pos = 1'b0;
        e = sb.pop_front(); n_vec++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
    endtask

    task automatic test_disarm();
        arm_sw = 1'b0;
        sb.push_back('{"disarm", pk(8'd7, 8'd0, 1'b0, 1'b0, 1'b0)});
        tick();
        e = sb.pop_front(); n_vec++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); end
    endtask

    initial begin
        test_reset();
        test_set_minute();
        test_ring_blink();
        test_timeout();
        test_stop_priority();
        test_snooze();
        test_reset_mid_ring();
        test_min_wrap();
        test_disarm();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
